// File: rtl/fp16_pkg.sv
// Shared fp16 helpers: special constants, classification functions and
// the reducer FSM state encoding.
package fp16_pkg;

  localparam logic [15:0] FP16_QNAN    = 16'h7E00;
  localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } state_t;

  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:10] == FP16_EXP_MAX) && (v[9:0] != '0);
  endfunction

  function automatic logic is_zero(input logic [15:0] v);
    return v[14:0] == '0;
  endfunction

  function automatic logic is_subnormal(input logic [15:0] v);
    return (v[14:10] == '0) && (v[9:0] != '0);
  endfunction

endpackage

// File: rtl/fp16_cmp.sv
// Scalar fp16 comparator: strict a<b / a>b orderings plus an unordered flag.
// +0 and -0 compare equal; any NaN operand makes the pair unordered.
module fp16_cmp
  import fp16_pkg::*;
(
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_lt,
  output logic        o_gt,
  output logic        o_unord
);

  logic [14:0] w_a_mag;
  logic [14:0] w_b_mag;

  assign w_a_mag = i_a[14:0];
  assign w_b_mag = i_b[14:0];

  // Sign-magnitude ordering; negative operands reverse the magnitude sense.
  always_comb begin
    o_lt    = 1'b0;
    o_gt    = 1'b0;
    o_unord = 1'b0;
    if (is_nan(i_a) || is_nan(i_b)) begin
      o_unord = 1'b1;
    end else if (is_zero(i_a) && is_zero(i_b)) begin
      o_lt = 1'b0;
      o_gt = 1'b0;
    end else if (i_a[15] != i_b[15]) begin
      o_lt = i_a[15];
      o_gt = ~i_a[15];
    end else if (w_a_mag != w_b_mag) begin
      if (i_a[15]) begin
        o_lt = w_a_mag > w_b_mag;
        o_gt = w_a_mag < w_b_mag;
      end else begin
        o_lt = w_a_mag < w_b_mag;
        o_gt = w_a_mag > w_b_mag;
      end
    end
  end

endmodule

// File: rtl/fp16_minmax_stream.sv
// Streaming fp16 min/max reducer. One element per cycle over valid/ready;
// per frame reports min/max values, first-occurrence indices, element count,
// NaN-seen and overflow flags, held until the result handshake.
// Optional build macro: FP16_MINMAX_FTZ_EN flushes subnormal inputs to a
// same-signed zero before comparison and storage.
module fp16_minmax_stream
  import fp16_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_min,
  output logic [15:0]      m_max,
  output logic [IDX_W-1:0] m_min_idx,
  output logic [IDX_W-1:0] m_max_idx,
  output logic [IDX_W:0]   m_count,
  output logic             m_nan,
  output logic             m_overflow
);

  state_t           r_state;
  logic [15:0]      r_min;
  logic [15:0]      r_max;
  logic [IDX_W-1:0] r_min_idx;
  logic [IDX_W-1:0] r_max_idx;
  logic [IDX_W:0]   r_count;
  logic             r_nan;
  logic             r_ovf;
  logic             r_have;
  logic             r_m_valid;

  logic [15:0]      w_data;
  logic             w_accept;
  logic             w_open;
  logic [IDX_W:0]   w_pos;
  logic             w_ovf_el;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W:0]   w_count_nx;
  logic             w_is_nan;
  logic             w_first;
  logic             w_min_lt;
  logic             w_min_unord;
  logic             w_max_gt;
  logic             w_max_unord;
  logic             w_upd_min;
  logic             w_upd_max;

`ifdef FP16_MINMAX_FTZ_EN
  assign w_data = is_subnormal(s_data) ? {s_data[15], 15'h0000} : s_data;
`else
  assign w_data = s_data;
`endif

  assign s_ready  = ~rst && (r_state != ST_HOLD);
  assign w_accept = s_valid && s_ready;

  // A frame is continuing only in ACCUM; in IDLE every per-frame register
  // is reloaded from the current element rather than cleared on handshake.
  assign w_open     = (r_state == ST_ACCUM);
  assign w_pos      = w_open ? r_count : '0;
  assign w_ovf_el   = w_pos[IDX_W];
  assign w_idx      = w_ovf_el ? '1 : w_pos[IDX_W-1:0];
  assign w_count_nx = w_ovf_el ? w_pos : w_pos + {{IDX_W{1'b0}}, 1'b1};
  assign w_is_nan   = is_nan(w_data);
  assign w_first    = ~w_open || ~r_have;

  fp16_cmp u_cmp_min (
    .i_a     (w_data),
    .i_b     (r_min),
    .o_lt    (w_min_lt),
    .o_gt    (),
    .o_unord (w_min_unord)
  );

  fp16_cmp u_cmp_max (
    .i_a     (w_data),
    .i_b     (r_max),
    .o_lt    (),
    .o_gt    (w_max_gt),
    .o_unord (w_max_unord)
  );

  // unord can only rise here for a NaN input, which is already steered away.
  assign w_upd_min = ~w_is_nan && (w_first || (w_min_lt && ~w_min_unord));
  assign w_upd_max = ~w_is_nan && (w_first || (w_max_gt && ~w_max_unord));

  // Frame FSM plus accumulation of min/max, indices, count and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_min     <= '0;
      r_max     <= '0;
      r_min_idx <= '0;
      r_max_idx <= '0;
      r_count   <= '0;
      r_nan     <= 1'b0;
      r_ovf     <= 1'b0;
      r_have    <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) begin
            r_count <= w_count_nx;
            r_nan   <= (w_open & r_nan) | w_is_nan;
            r_ovf   <= (w_open & r_ovf) | w_ovf_el;
            r_have  <= (w_open & r_have) | ~w_is_nan;
            if (w_upd_min) begin
              r_min     <= w_data;
              r_min_idx <= w_idx;
            end else if (!w_open) begin
              r_min     <= FP16_QNAN;
              r_min_idx <= '0;
            end
            if (w_upd_max) begin
              r_max     <= w_data;
              r_max_idx <= w_idx;
            end else if (!w_open) begin
              r_max     <= FP16_QNAN;
              r_max_idx <= '0;
            end
            if (s_last) begin
              r_state   <= ST_HOLD;
              r_m_valid <= 1'b1;
            end else begin
              r_state   <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (m_ready) begin
            r_state   <= ST_IDLE;
            r_m_valid <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid    = r_m_valid;
  assign m_min      = r_min;
  assign m_max      = r_max;
  assign m_min_idx  = r_min_idx;
  assign m_max_idx  = r_max_idx;
  assign m_count    = r_count;
  assign m_nan      = r_nan;
  assign m_overflow = r_ovf;

endmodule

// File: tb/tb_fp16_minmax_stream.sv
// Directed bench for fp16_minmax_stream: a default-width instance and an
// IDX_W=2 instance share all inputs so overflow can be checked cheaply.
module tb_fp16_minmax_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_last;
  logic        m_ready;

  logic        s_ready, m_valid, m_nan, m_overflow;
  logic [15:0] m_min, m_max;
  logic [7:0]  m_min_idx, m_max_idx;
  logic [8:0]  m_count;

  logic        sm_s_ready, sm_valid, sm_nan, sm_overflow;
  logic [15:0] sm_min, sm_max;
  logic [1:0]  sm_min_idx, sm_max_idx;
  logic [2:0]  sm_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp16_minmax_stream #(.IDX_W(8)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_min(m_min), .m_max(m_max), .m_min_idx(m_min_idx), .m_max_idx(m_max_idx),
    .m_count(m_count), .m_nan(m_nan), .m_overflow(m_overflow)
  );

  fp16_minmax_stream #(.IDX_W(2)) u_dut_small (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(sm_s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(sm_valid), .m_ready(m_ready),
    .m_min(sm_min), .m_max(sm_max), .m_min_idx(sm_min_idx), .m_max_idx(sm_max_idx),
    .m_count(sm_count), .m_nan(sm_nan), .m_overflow(sm_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present one element and wait (bounded) for it to be accepted.
  task automatic send(input logic [15:0] d, input logic l);
    logic ok;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic end_frame;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("latency_valid", {31'd0, m_valid}, 32'd1);
  endtask

  task automatic check_res(input string t, input logic [15:0] mn, input logic [7:0] mni,
                           input logic [15:0] mx, input logic [7:0] mxi,
                           input logic [8:0] cnt, input logic nan, input logic ovf);
    chk({t, "_min"},     {16'd0, m_min},      {16'd0, mn});
    chk({t, "_min_idx"}, {24'd0, m_min_idx},  {24'd0, mni});
    chk({t, "_max"},     {16'd0, m_max},      {16'd0, mx});
    chk({t, "_max_idx"}, {24'd0, m_max_idx},  {24'd0, mxi});
    chk({t, "_count"},   {23'd0, m_count},    {23'd0, cnt});
    chk({t, "_nan"},     {31'd0, m_nan},      {31'd0, nan});
    chk({t, "_ovf"},     {31'd0, m_overflow}, {31'd0, ovf});
  endtask

  task automatic handshake(input string t);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    chk({t, "_hs_valid"}, {31'd0, m_valid}, 32'd0);
    chk({t, "_hs_ready"}, {31'd0, s_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", {31'd0, s_ready},    32'd0);
    chk("rst_m_valid", {31'd0, m_valid},    32'd0);
    chk("rst_min",     {16'd0, m_min},      32'd0);
    chk("rst_max",     {16'd0, m_max},      32'd0);
    chk("rst_count",   {23'd0, m_count},    32'd0);
    chk("rst_idx",     {16'd0, m_min_idx, m_max_idx}, 32'd0);
    chk("rst_flags",   {30'd0, m_nan, m_overflow},    32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'd0, s_ready}, 32'd1);

    // Basic frame
    send(16'h3C00, 1'b0);
    send(16'hC000, 1'b0);
    send(16'h4200, 1'b0);
    chk("basic_no_early_valid", {31'd0, m_valid}, 32'd0);
    send(16'h0000, 1'b1);
    end_frame();
    check_res("basic", 16'hC000, 8'd1, 16'h4200, 8'd2, 9'd4, 1'b0, 1'b0);
    handshake("basic");

    // NaNs skipped but counted
    send(16'h7E00, 1'b0);
    send(16'h3800, 1'b0);
    send(16'h7C01, 1'b1);
    end_frame();
    check_res("nanskip", 16'h3800, 8'd1, 16'h3800, 8'd1, 9'd3, 1'b1, 1'b0);
    handshake("nanskip");

    // All-NaN single-element frame
    send(16'h7E00, 1'b1);
    end_frame();
    check_res("allnan", 16'h7E00, 8'd0, 16'h7E00, 8'd0, 9'd1, 1'b1, 1'b0);
    handshake("allnan");

    // Ties and signed zeros keep the earliest
    send(16'h8000, 1'b0);
    send(16'h0000, 1'b0);
    send(16'h8000, 1'b1);
    end_frame();
    check_res("zeros", 16'h8000, 8'd0, 16'h8000, 8'd0, 9'd3, 1'b0, 1'b0);
    handshake("zeros");

    // Subnormals
    send(16'h0001, 1'b0);
    send(16'h8001, 1'b1);
    end_frame();
`ifdef FP16_MINMAX_FTZ_EN
    check_res("subn", 16'h0000, 8'd0, 16'h0000, 8'd0, 9'd2, 1'b0, 1'b0);
`else
    check_res("subn", 16'h8001, 8'd1, 16'h0001, 8'd0, 9'd2, 1'b0, 1'b0);
`endif
    handshake("subn");

    // Infinities with backpressure; s_valid junk during HOLD must be ignored
    send(16'hFC00, 1'b0);
    send(16'h7C00, 1'b1);
    chk("inf_latency_valid", {31'd0, m_valid}, 32'd1);
    s_data = 16'h1234;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_ready", {31'd0, s_ready}, 32'd0);
      chk("bp_min",   {16'd0, m_min},   32'h0000FC00);
      chk("bp_max",   {16'd0, m_max},   32'h00007C00);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_res("inf", 16'hFC00, 8'd0, 16'h7C00, 8'd1, 9'd2, 1'b0, 1'b0);
    handshake("inf");

    // Reset mid-frame discards the partial frame
    send(16'h3C00, 1'b0);
    send(16'h4400, 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", {31'd0, s_ready}, 32'd0);
    rst = 1'b0;
    chk("midrst_valid0", {31'd0, m_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_valid1", {31'd0, m_valid}, 32'd0);
    send(16'h4000, 1'b1);
    end_frame();
    check_res("afterrst", 16'h4000, 8'd0, 16'h4000, 8'd0, 9'd1, 1'b0, 1'b0);
    handshake("afterrst");

    // 5-element frame: overflows the IDX_W=2 instance only
    for (int i = 0; i < 5; i++) send((i == 4) ? 16'h4000 : 16'h3C00, i == 4);
    end_frame();
    check_res("five", 16'h3C00, 8'd0, 16'h4000, 8'd4, 9'd5, 1'b0, 1'b0);
    chk("sm_five_count", {29'd0, sm_count},    32'd4);
    chk("sm_five_ovf",   {31'd0, sm_overflow}, 32'd1);
    chk("sm_five_maxi",  {30'd0, sm_max_idx},  32'd3);
    chk("sm_five_mini",  {30'd0, sm_min_idx},  32'd0);
    chk("sm_five_max",   {16'd0, sm_max},      32'h00004000);
    handshake("five");

    // 257-element frame: overflows the default instance
    for (int i = 0; i < 257; i++)
      send((i == 3) ? 16'hBC00 : ((i == 256) ? 16'h4000 : 16'h3C00), i == 256);
    end_frame();
    check_res("big", 16'hBC00, 8'd3, 16'h4000, 8'd255, 9'd256, 1'b0, 1'b1);
    chk("sm_big_count", {29'd0, sm_count},    32'd4);
    chk("sm_big_ovf",   {31'd0, sm_overflow}, 32'd1);
    chk("sm_big_idx",   {28'd0, sm_min_idx, sm_max_idx}, 32'hF);
    handshake("big");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
